// File: rtl/gpr_writeback.sv
`default_nettype none
// ============================================================================
// Module      : gpr_writeback
// Description : GPR write-back arbiter. ALU results have priority. Memory
//               results wait in a small FIFO, and a younger ALU write kills them.
// Revision    : 1.0 - initial release
// ============================================================================
module gpr_writeback #(
    parameter int DEPTH = 2
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        AluValid,
    input  logic [4:0]  AluReg,
    input  logic [31:0] AluData,
    input  logic        MemValid,
    output logic        MemReady,
    input  logic [4:0]  MemReg,
    input  logic [31:0] MemData,
    output logic        RegWrite,
    output logic [4:0]  WriteRegisterSelect,
    output logic [31:0] WriteData,
    output logic [31:0] PendingMask
);

    localparam int             c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_PTR_W:0] c_DEPTH = (c_PTR_W + 1)'(DEPTH);

    logic [4:0]         r_regs   [DEPTH];
    logic [31:0]        r_data   [DEPTH];
    logic               r_valid  [DEPTH];
    logic               r_killed [DEPTH];
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_PTR_W:0]   r_count;
    logic               r_regWrite;
    logic [4:0]         r_wrSel;
    logic [31:0]        r_wrData;

    logic               w_aluWrite;
    logic               w_pop;
    logic               w_push;
    logic [31:0]        w_pendingMask;

    assign MemReady   = (r_count < c_DEPTH);
    assign w_aluWrite = AluValid && (AluReg != 5'd0);
    assign w_pop      = !w_aluWrite && (r_count != '0);
    // Writes to r0 complete the handshake but never occupy a slot
    assign w_push     = MemValid && MemReady && (MemReg != 5'd0);

    always_comb begin
        w_pendingMask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && !r_killed[i]) begin
                w_pendingMask[r_regs[i]] = 1'b1;
            end
        end
        w_pendingMask[0] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_regWrite <= 1'b0;
            r_wrSel    <= 5'd0;
            r_wrData   <= 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i]   <= 5'd0;
                r_data[i]   <= 32'd0;
                r_valid[i]  <= 1'b0;
                r_killed[i] <= 1'b0;
            end
        end else begin
            r_regWrite <= 1'b0;
            if (w_aluWrite) begin
                r_regWrite <= 1'b1;
                r_wrSel    <= AluReg;
                r_wrData   <= AluData;
                // Older buffered results to the same register are now stale
                for (int i = 0; i < DEPTH; i++) begin
                    if (r_valid[i] && (r_regs[i] == AluReg)) begin
                        r_killed[i] <= 1'b1;
                    end
                end
            end else if (w_pop) begin
                if (!r_killed[r_head]) begin
                    r_regWrite <= 1'b1;
                    r_wrSel    <= r_regs[r_head];
                    r_wrData   <= r_data[r_head];
                end
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + c_PTR_W'(1);
            end
            // The push slot is never valid here, so it cannot collide with the kill loop
            if (w_push) begin
                r_regs[r_tail]   <= MemReg;
                r_data[r_tail]   <= MemData;
                r_valid[r_tail]  <= 1'b1;
                r_killed[r_tail] <= 1'b0;
                r_tail           <= r_tail + c_PTR_W'(1);
            end
            r_count <= r_count + {{c_PTR_W{1'b0}}, w_push} - {{c_PTR_W{1'b0}}, w_pop};
        end
    end

    assign RegWrite            = r_regWrite;
    assign WriteRegisterSelect = r_wrSel;
    assign WriteData           = r_wrData;
    assign PendingMask         = w_pendingMask;

endmodule
`default_nettype wire

// File: tb/tb_gpr_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpr_writeback
// Description : Scoreboard bench for gpr_writeback (directed scenarios + random).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpr_writeback;

    localparam int DEPTH = 2;

    logic        CLK;
    logic        Reset;
    logic        AluValid;
    logic [4:0]  AluReg;
    logic [31:0] AluData;
    logic        MemValid;
    logic        MemReady;
    logic [4:0]  MemReg;
    logic [31:0] MemData;
    logic        RegWrite;
    logic [4:0]  WriteRegisterSelect;
    logic [31:0] WriteData;
    logic [31:0] PendingMask;

    gpr_writeback #(.DEPTH(DEPTH)) dut (
        .CLK                 (CLK),
        .Reset               (Reset),
        .AluValid            (AluValid),
        .AluReg              (AluReg),
        .AluData             (AluData),
        .MemValid            (MemValid),
        .MemReady            (MemReady),
        .MemReg              (MemReg),
        .MemData             (MemData),
        .RegWrite            (RegWrite),
        .WriteRegisterSelect (WriteRegisterSelect),
        .WriteData           (WriteData),
        .PendingMask         (PendingMask)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
        logic        k;
    } ent_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  r;
        logic [31:0] d;
    } exp_t;

    ent_t        mq[$];
    exp_t        sb[$];
    logic [4:0]  lastReg;
    logic [31:0] lastData;
    int          nTests;
    int          nFail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] modelMask();
        logic [31:0] m;
        m = '0;
        foreach (mq[i]) if (!mq[i].k) m[mq[i].r] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    // One clock: drive, check combinational outputs, step model, check registered outputs
    task automatic cyc(input logic rst, input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md);
        exp_t e;
        ent_t h;
        logic ready;
        @(negedge CLK);
        Reset = rst; AluValid = av; AluReg = ar; AluData = ad;
        MemValid = mv; MemReg = mr; MemData = md;
        #1;
        if (rst) begin
            mq.delete();
            lastReg = '0; lastData = '0;
            e = '{we: 1'b0, r: 5'd0, d: 32'd0};
        end else begin
            ready = (mq.size() < DEPTH);
            check("MemReady", {31'd0, MemReady}, {31'd0, ready});
            check("PendingMask", PendingMask, modelMask());
            e = '{we: 1'b0, r: lastReg, d: lastData};
            if (av && ar != 5'd0) begin
                e = '{we: 1'b1, r: ar, d: ad};
                foreach (mq[i]) if (mq[i].r == ar) mq[i].k = 1'b1;
            end else if (mq.size() > 0) begin
                h = mq.pop_front();
                if (!h.k) e = '{we: 1'b1, r: h.r, d: h.d};
            end
            if (mv && ready && mr != 5'd0) mq.push_back('{r: mr, d: md, k: 1'b0});
            if (e.we) begin
                lastReg = e.r; lastData = e.d;
            end
        end
        sb.push_back(e);
        @(posedge CLK);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("RegWrite", {31'd0, RegWrite}, {31'd0, e.we});
            check("WriteRegisterSelect", {27'd0, WriteRegisterSelect}, {27'd0, e.r});
            check("WriteData", WriteData, e.d);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        nTests = 0; nFail = 0;
        lastReg = '0; lastData = '0;
        Reset = 1'b1; AluValid = 1'b0; AluReg = '0; AluData = '0;
        MemValid = 1'b0; MemReg = '0; MemData = '0;

        cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        idle(1);

        // ALU-only write
        cyc(1'b0, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
        idle(2);

        // Mem result stalled behind two ALU writes
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hAAAA);
        cyc(1'b0, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
        cyc(1'b0, 1'b1, 5'd3, 32'h34, 1'b0, 5'd0, 32'd0);
        idle(2);

        // Fill the buffer, hold MemValid through the full condition
        cyc(1'b0, 1'b1, 5'd10, 32'hA0, 1'b1, 5'd1, 32'h11);
        cyc(1'b0, 1'b1, 5'd10, 32'hA1, 1'b1, 5'd2, 32'h22);
        cyc(1'b0, 1'b1, 5'd10, 32'hA2, 1'b1, 5'd4, 32'h44);
        check("full_mask", PendingMask, 32'h6);
        check("full_ready", {31'd0, MemReady}, 32'd0);
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h44);
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h44);
        idle(3);

        // Kill of a buffered entry by a later ALU write
        cyc(1'b0, 1'b1, 5'd11, 32'hB0, 1'b1, 5'd9, 32'h1);
        cyc(1'b0, 1'b1, 5'd9, 32'h2, 1'b0, 5'd0, 32'd0);
        check("kill_mask", PendingMask, 32'h0);
        idle(2);

        // Same-cycle Mem and ALU to one register: Mem entry is younger and survives
        cyc(1'b0, 1'b1, 5'd12, 32'hC0, 1'b1, 5'd12, 32'hC1);
        idle(2);

        // r0 handling on both paths
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD);
        cyc(1'b0, 1'b1, 5'd6, 32'h60, 1'b1, 5'd3, 32'h30);
        cyc(1'b0, 1'b1, 5'd0, 32'hBAD, 1'b0, 5'd0, 32'd0);
        idle(1);

        // Reset with two buffered entries
        cyc(1'b0, 1'b1, 5'd8, 32'h80, 1'b1, 5'd13, 32'hD0);
        cyc(1'b0, 1'b1, 5'd8, 32'h81, 1'b1, 5'd14, 32'hE0);
        cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        idle(3);

        // Random traffic on a narrow register range to provoke kills
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 60) == 0),
                ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 5)), $urandom,
                ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 5)), $urandom);
        end
        idle(3);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gpr_writeback.md
GPR_WRITEBACK -- requirements
Module: gpr_writeback

Interface
REQ-001 Parameter: DEPTH, default 2, number of entries in the memory-result buffer (power of two, >=2).
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset, sampled on rising CLK edge.
REQ-004 AluValid  input  1  ALU result valid this cycle; no backpressure.
REQ-005 AluReg  input  5  ALU destination register number.
REQ-006 AluData  input  32  ALU result.
REQ-007 MemValid  input  1  load/multi-cycle result offered.
REQ-008 MemReady  output  1  buffer can accept a Mem result this cycle.
REQ-009 MemReg  input  5  Mem destination register number.
REQ-010 MemData  input  32  Mem result.
REQ-011 RegWrite  output  1  register-file write enable, registered.
REQ-012 WriteRegisterSelect  output  5  register-file write address, registered.
REQ-013 WriteData  output  32  register-file write data, registered.
REQ-014 PendingMask  output  32  bit r set while a live buffered write to register r exists.

Function
REQ-015 Mem accept occurs when MemValid && MemReady at a rising edge; MemReady = (live entry count < DEPTH), combinational from current state only.
REQ-016 An accepted Mem result with MemReg==0 completes the handshake but is discarded (no entry allocated).
REQ-017 Buffer is FIFO; entries written at tail, issued from head; pointers wrap modulo DEPTH.
REQ-018 Per cycle, issue selection: AluValid && AluReg!=0 -> ALU result; else buffer non-empty -> head entry; else no write.
REQ-019 Selected write appears on RegWrite/WriteRegisterSelect/WriteData after the next rising edge (1-cycle latency); when no write is selected, RegWrite=0 and address/data hold previous values.
REQ-020 AluValid with AluReg==0 issues nothing and does not block the buffer that cycle.
REQ-021 Mem latency: accept at edge N with empty buffer and no ALU write in cycle N+1 -> RegWrite=1 after edge N+1.
REQ-022 Ordering: buffered entries are older than a concurrent ALU result; an ALU write to register r kills all entries for r present in the buffer before that edge.
REQ-023 A Mem entry accepted in the same cycle as an ALU write to the same register is younger and is not killed.
REQ-024 A killed entry remains in the buffer; when it reaches head and is selected, it is popped with RegWrite=0 for that cycle.
REQ-025 Killed entries do not count as live for PendingMask but do occupy buffer slots for MemReady.
REQ-026 Full buffer with simultaneous pop: MemReady stays 0 that cycle (no same-cycle push-through).
REQ-027 PendingMask bit 0 is always 0; PendingMask is derived from current buffer contents only.

Reset
REQ-028 While Reset=1 at an edge: buffer emptied, all pointers and kill flags cleared, RegWrite=0, WriteRegisterSelect=0, WriteData=0.
REQ-029 Reset mid-operation discards all buffered and killed entries; no write is issued in the cycle after reset.
REQ-030 After reset: MemReady=1, PendingMask=0.

Verification
REQ-031 ALU only: AluValid=1, AluReg=5, AluData=32'h1234 one cycle -> next cycle RegWrite=1, WriteRegisterSelect=5, WriteData=32'h1234; following cycle RegWrite=0.
REQ-032 Mem with ALU contention: accept Mem r7=32'hAAAA, then AluValid r3 for 2 cycles -> r3 written twice, then r7=32'hAAAA; PendingMask bit7 set until r7 issue.
REQ-033 Full buffer (DEPTH=2): accept r1, r2 while ALU busy -> MemReady=0, PendingMask=32'h6; MemValid held is not accepted until one entry pops.
REQ-034 Kill: buffer holds r9=32'h1, ALU writes r9=32'h2 -> r9=32'h2 issued, buffered entry later pops with RegWrite=0; PendingMask bit9 clears at ALU edge.
REQ-035 R0 handling: Mem r0 accepted -> no entry, MemReady unaffected; AluValid r0 -> no write, buffered head issues instead.
REQ-036 Reset with 2 entries buffered -> next cycle RegWrite=0, PendingMask=0, MemReady=1; no stale writes ever appear.
